ccip_c0tx_arbiter: RTL

Shares the single CCI-P C0 Tx read-request channel between `NUM_REQ` AFU-side requesters. It buffers each requester's read requests in a small per-requester FIFO and issues them round-robin while honouring `C0TxAlmFull`. It tags `mdata` with the requester ID and steers the matching C0 Rx read responses back to the owning requester. It sits between the AFU sub-engines and the CCI-P port, upstream of the transaction logger taps.

---
 rtl/ase_pkg.sv | 37 +++
 rtl/ccip_req_fifo.sv | 54 +++++
 rtl/ccip_c0tx_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ase_pkg.sv
// ase_pkg: CCI-P header types, data width and request/response encodings
package ase_pkg;

    localparam int CCIP_DATA_WIDTH   = 512;
    localparam int CCIP_MDATA_ID_MSB = 15;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h4,
        eREQ_RDLINE_S = 4'h5
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic [1:0]  rsvd1;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [5:0]  rsvd0;
        logic [41:0] address;
        logic [15:0] mdata;
    } TxHdr_t;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } RxHdr_t;

endpackage

// File: rtl/ccip_req_fifo.sv
// ccip_req_fifo: per-requester header FIFO; an empty FIFO presents its write data so a push can be granted in the same cycle
module ccip_req_fifo
    import ase_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  TxHdr_t                  i_wr_data,
    input  logic                    i_pop,
    output TxHdr_t                  o_head,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int AW = $clog2(DEPTH);

    TxHdr_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_bypass;
    logic          w_wr;
    logic          w_rd;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_count  = r_count;
    assign o_head   = o_empty ? i_wr_data : r_mem[r_rd];
    // a pop of an empty FIFO consumes the incoming push directly, never touching storage
    assign w_bypass = o_empty && i_pop;
    // a pop frees the slot first, so a push into a full FIFO is accepted when it is also popped
    assign w_wr     = i_push && !w_bypass && (!o_full || i_pop);
    assign w_rd     = i_pop && !o_empty;

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + AW'(1);
            if (w_rd) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end

    // payload storage, no reset needed since occupancy guards every read
    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr] <= i_wr_data;

endmodule

// File: rtl/ccip_c0tx_arbiter.sv
// ccip_c0tx_arbiter: round-robin sharing of the C0 Tx read channel with mdata ID tagging and C0 Rx response steering
module ccip_c0tx_arbiter
    import ase_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int IDW        = $clog2(NUM_REQ)
)(
    input  logic                             clk,
    input  logic                             sys_reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  TxHdr_t [NUM_REQ-1:0]             req_hdr,
    output logic [NUM_REQ-1:0]               req_almfull,
    output logic [NUM_REQ-1:0]               req_overflow,
    output TxHdr_t                           C0TxHdr,
    output logic                             C0TxRdValid,
    input  logic                             C0TxAlmFull,
    input  RxHdr_t                           C0RxHdr,
    input  logic [CCIP_DATA_WIDTH-1:0]       C0RxData,
    input  logic                             C0RxRdValid,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output RxHdr_t                           rsp_hdr,
    output logic [CCIP_DATA_WIDTH-1:0]       rsp_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(NUM_REQ);

    TxHdr_t [NUM_REQ-1:0]          w_tagged;
    TxHdr_t [NUM_REQ-1:0]          w_head;
    logic [NUM_REQ-1:0][CW-1:0]    w_count;
    logic [NUM_REQ-1:0]            w_full;
    logic [NUM_REQ-1:0]            w_empty;
    logic [NUM_REQ-1:0]            w_avail;
    logic [NUM_REQ-1:0]            w_pop;
    logic                          w_found;
    logic                          w_grant;
    logic [PW-1:0]                 w_win;
    int                            w_idx;
    logic [IDW-1:0]                w_rsp_id;
    RxHdr_t                        w_rx_clr;

    logic [PW-1:0]                 r_rr;
    logic                          r_valid;
    TxHdr_t                        r_hdr;
    logic [NUM_REQ-1:0]            r_almfull;
    logic [NUM_REQ-1:0]            r_ovf;
    logic [NUM_REQ-1:0]            r_rsp_valid;
    RxHdr_t                        r_rsp_hdr;
    logic [CCIP_DATA_WIDTH-1:0]    r_rsp_data;

    function automatic TxHdr_t tag_id(input TxHdr_t h, input int id);
        tag_id = h;
        tag_id.mdata[CCIP_MDATA_ID_MSB -: IDW] = IDW'(id);
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
        assign w_tagged[i] = tag_id(req_hdr[i], i);
        ccip_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (sys_reset),
            .i_push    (req_valid[i]),
            .i_wr_data (w_tagged[i]),
            .i_pop     (w_pop[i]),
            .o_head    (w_head[i]),
            .o_count   (w_count[i]),
            .o_full    (w_full[i]),
            .o_empty   (w_empty[i])
        );
    end

    // a requester competes if it has queued work or is pushing into its empty FIFO this cycle
    assign w_avail = ~w_empty | req_valid;
    assign w_grant = w_found && !C0TxAlmFull;
    assign w_pop   = w_grant ? NUM_REQ'(1) << w_win : '0;

    // first competing requester at or after the round-robin pointer, wrapping upward
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && w_avail[w_idx]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
    end

    // registered channel request; header and pointer hold when nothing is granted
    always_ff @(posedge clk or posedge sys_reset)
        if (sys_reset) begin
            r_valid <= 1'b0;
            r_hdr   <= '0;
            r_rr    <= '0;
        end else begin
            r_valid <= w_grant;
            if (w_grant) begin
                r_hdr <= w_head[w_win];
                r_rr  <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + PW'(1);
            end
        end

    // back-pressure decoded from the registered counts, sticky drop flags
    always_ff @(posedge clk or posedge sys_reset)
        if (sys_reset) begin
            r_almfull <= '0;
            r_ovf     <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                r_almfull[k] <= w_count[k] >= CW'(FIFO_DEPTH - 2);
                if (req_valid[k] && w_full[k] && !w_pop[k]) r_ovf[k] <= 1'b1;
            end
        end

    assign w_rsp_id = C0RxHdr.mdata[CCIP_MDATA_ID_MSB -: IDW];

    // response header handed back with the routing ID stripped
    always_comb begin
        w_rx_clr = C0RxHdr;
        w_rx_clr.mdata[CCIP_MDATA_ID_MSB -: IDW] = '0;
    end

    // one-cycle response steering; IDs beyond the requester count are dropped
    always_ff @(posedge clk or posedge sys_reset)
        if (sys_reset) begin
            r_rsp_valid <= '0;
            r_rsp_hdr   <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= (C0RxRdValid && int'(w_rsp_id) < NUM_REQ) ? NUM_REQ'(1) << w_rsp_id : '0;
            if (C0RxRdValid) begin
                r_rsp_hdr  <= w_rx_clr;
                r_rsp_data <= C0RxData;
            end
        end

    assign C0TxRdValid  = r_valid;
    assign C0TxHdr      = r_hdr;
    assign req_almfull  = r_almfull;
    assign req_overflow = r_ovf;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_hdr      = r_rsp_hdr;
    assign rsp_data     = r_rsp_data;

endmodule
